// File: rtl/md_pkg.sv
// Shared encodings, FSM state type and default latencies for the mult/div issue logic.
package md_pkg;

  // Operation codes presented on ex_md_ctr / MD_ctr
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam logic [2:0] MD_MADD  = 3'b110;
  localparam logic [2:0] MD_NOP   = 3'b111;

  // Default unit latencies and watchdog limit (cycles)
  localparam int unsigned MUL_LAT_DEF  = 4;
  localparam int unsigned DIV_LAT_DEF  = 9;
  localparam int unsigned WDOG_MAX_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10,
    ST_DRAIN  = 2'b11
  } md_state_e;

  // mult/multu/div/divu all have bit 2 clear
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_mt(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Tracks the expected Busy duration of a launched op and flags latency
// mismatches and watchdog timeouts. Both counters start at launch.
module md_lat_counter
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,      // op launched this cycle
  input  logic is_div_i,    // launched op is div/divu
  input  logic track_i,     // FSM in LAUNCH or WAIT
  input  logic done_i,      // FSM in WAIT and Busy low
  input  logic busy_i,
  output logic mismatch_o,
  output logic timeout_o
);

  localparam int unsigned MAX_A = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned MAX_V = (MAX_A > WDOG_MAX) ? MAX_A : WDOG_MAX;
  localparam int          CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] MUL_W  = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_W  = CW'(DIV_LAT);
  localparam logic [CW-1:0] WDOG_W = CW'(WDOG_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wd_q, wd_d;

  // Next-state: load on launch, then count Busy cycles down (latency) and up (watchdog)
  always_comb begin
    cnt_d = cnt_q;
    wd_d  = wd_q;
    if (load_i) begin
      cnt_d = is_div_i ? DIV_W : MUL_W;
      wd_d  = '0;
    end else if (track_i && busy_i) begin
      cnt_d = (cnt_q != '0) ? (cnt_q - CW'(1)) : cnt_q;
      wd_d  = (wd_q != WDOG_W) ? (wd_q + CW'(1)) : wd_q;
    end else begin
      cnt_d = cnt_q;
      wd_d  = wd_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wd_q  <= wd_d;
    end
  end

  // Busy still high with no latency left, or Busy dropped early
  assign mismatch_o = (track_i && busy_i && (cnt_q == '0)) || (done_i && (cnt_q != '0));
  // This would be Busy cycle WDOG_MAX+1
  assign timeout_o  = track_i && busy_i && (wd_q == WDOG_W);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/stall controller between the EX stage and the multiply/divide unit.
// Issue outputs are driven in the same cycle the EX instruction is accepted so
// that an mthi/mtlo is visible to an mfhi/mflo in the very next cycle.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_md_ctr,
  input  logic        ex_is_mf,
  input  logic        ex_mf_sel,
  input  logic        ex_flush,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        Busy,
  input  logic [31:0] HIO,
  input  logic [31:0] LOO,
  output logic        Start,
  output logic [2:0]  MD_ctr,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        stall,
  output logic [31:0] mf_result,
  output logic        illegal_op,
  output logic        lat_err
);

  md_state_e state_q;
  logic      lat_err_q;

  logic live_s, idle_s, issue_md_s, issue_mt_s;
  logic track_s, done_s, mismatch_s, timeout_s;

  // Issue decode and outputs; reset gates everything so outputs clear without a clock
  always_comb begin
    live_s     = reset & ex_valid & ~ex_flush;
    idle_s     = (state_q == ST_IDLE);
    issue_md_s = live_s & idle_s & is_muldiv(ex_md_ctr);
    issue_mt_s = live_s & idle_s & is_mt(ex_md_ctr);
    track_s    = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    done_s     = (state_q == ST_WAIT) && !Busy;

    Start      = issue_md_s;
    MD_ctr     = (issue_md_s | issue_mt_s) ? ex_md_ctr : MD_NOP;
    RD1        = (issue_md_s | issue_mt_s) ? ex_rs : 32'h0000_0000;
    RD2        = issue_md_s ? ex_rt : 32'h0000_0000;
    illegal_op = live_s & idle_s & ((ex_md_ctr == MD_MADD) || (ex_md_ctr == MD_NOP));
    stall      = reset & (ex_valid | ex_is_mf) & ~ex_flush & ~idle_s;
    mf_result  = reset ? (ex_mf_sel ? LOO : HIO) : 32'h0000_0000;
    lat_err    = lat_err_q;
  end

  md_lat_counter #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .WDOG_MAX (WDOG_MAX)
  ) u_lat (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (issue_md_s),
    .is_div_i   (ex_md_ctr[1]),
    .track_i    (track_s),
    .done_i     (done_s),
    .busy_i     (Busy),
    .mismatch_o (mismatch_s),
    .timeout_o  (timeout_s)
  );

  // Launch/wait/drain sequencing plus the sticky latency error flag.
  // LAUNCH gives the unit a cycle to raise Busy; DRAIN covers the HI/LO write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lat_err_q <= 1'b0;
    end else begin
      lat_err_q <= lat_err_q | mismatch_s | timeout_s;
      case (state_q)
        ST_IDLE:   state_q <= issue_md_s ? ST_LAUNCH : ST_IDLE;
        ST_LAUNCH: state_q <= timeout_s ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          if (timeout_s) begin
            state_q <= ST_IDLE;
          end else if (!Busy) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DRAIN:  state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a behavioural mult/div unit, directed scenarios and
// a randomized phase checked against a cycle-count model of the issue rules.
module tb_md_issue_ctrl;

  localparam int MUL_LAT  = 4;
  localparam int DIV_LAT  = 9;
  localparam int WDOG_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_is_mf, ex_mf_sel, ex_flush;
  logic [2:0]  ex_md_ctr;
  logic [31:0] ex_rs, ex_rt;
  logic        Busy;
  logic [31:0] HIO, LOO;
  logic        Start, stall, illegal_op, lat_err;
  logic [2:0]  MD_ctr;
  logic [31:0] RD1, RD2, mf_result;

  int n_total = 0;
  int n_bad   = 0;

  md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .WDOG_MAX(WDOG_MAX)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_md_ctr(ex_md_ctr),
    .ex_is_mf(ex_is_mf), .ex_mf_sel(ex_mf_sel), .ex_flush(ex_flush),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .Busy(Busy), .HIO(HIO), .LOO(LOO),
    .Start(Start), .MD_ctr(MD_ctr), .RD1(RD1), .RD2(RD2), .stall(stall),
    .mf_result(mf_result), .illegal_op(illegal_op), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural multiply/divide unit ----------------
  logic [31:0] u_hi = 32'h0;
  logic [31:0] u_lo = 32'h0;
  logic [31:0] p_hi = 32'h0;
  logic [31:0] p_lo = 32'h0;
  int          u_rem = 0;
  int          busy_override = 0;  // nonzero: Busy length for the next launch

  assign Busy = (u_rem != 0);
  assign HIO  = u_hi;
  assign LOO  = u_lo;

  function automatic logic [63:0] md_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    r  = 64'h0;
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = 64'(ua * ub);
      3'd2: if (b != 32'h0) r = {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b != 32'h0) r = {32'(ua % ub), 32'(ua / ub)};
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // Busy is high for the LAT cycles after Start is sampled; HI/LO land as Busy falls
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_rem <= 0;
      u_hi  <= 32'h0;
      u_lo  <= 32'h0;
    end else begin
      if (Start) begin
        u_rem <= (busy_override > 0) ? busy_override : (MD_ctr[1] ? DIV_LAT : MUL_LAT);
        {p_hi, p_lo} <= md_calc(MD_ctr, RD1, RD2);
      end else if (u_rem != 0) begin
        u_rem <= u_rem - 1;
        if (u_rem == 1) begin
          u_hi <= p_hi;
          u_lo <= p_lo;
        end
      end
      if (!Start && MD_ctr == 3'b100) u_hi <= RD1;
      if (!Start && MD_ctr == 3'b101) u_lo <= RD1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    ex_md_ctr = 3'b111;
    ex_is_mf  = 1'b0;
    ex_mf_sel = 1'b0;
    ex_flush  = 1'b0;
    ex_rs     = 32'h0;
    ex_rt     = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    ex_valid  = 1'b1;
    ex_md_ctr = op;
    ex_rs     = a;
    ex_rt     = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, {31'h0, Start}, 32'h0);
    chk({tag, "_mdctr"}, {29'h0, MD_ctr}, 32'h7);
    chk({tag, "_rd1"}, RD1, 32'h0);
    chk({tag, "_rd2"}, RD2, 32'h0);
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    chk({tag, "_mf"}, mf_result, 32'h0);
    chk({tag, "_illegal"}, {31'h0, illegal_op}, 32'h0);
    chk({tag, "_laterr"}, {31'h0, lat_err}, 32'h0);
  endtask

  // random-phase model state
  int   cyc, free_at, lat;
  logic m_idle, m_live, e_start, e_ill, e_stall;
  logic [2:0] e_md;

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1 reset = 1'b0;
    // live-looking EX inputs during reset must not leak to the outputs
    ex_valid = 1'b1; ex_md_ctr = 3'b000; ex_is_mf = 1'b1; ex_rs = 32'h1111_2222; ex_rt = 32'h3;
    #2 check_reset_outputs("rst");
    ex_md_ctr = 3'b110;
    #1 chk("rst_madd_illegal", {31'h0, illegal_op}, 32'h0);
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    next_cycle();

    // mult 7 * -3, then mflo / mfhi
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    chk("mult_start", {31'h0, Start}, 32'h1);
    chk("mult_mdctr", {29'h0, MD_ctr}, 32'h0);
    chk("mult_rd1", RD1, 32'd7);
    chk("mult_rd2", RD2, 32'hFFFF_FFFD);
    chk("mult_issue_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    idle_inputs(); ex_is_mf = 1'b1; ex_mf_sel = 1'b1;
    for (int k = 1; k <= MUL_LAT + 2; k++) begin
      @(negedge clk);
      chk("mult_stall", {31'h0, stall}, 32'h1);
      chk("mult_start_low", {31'h0, Start}, 32'h0);
      chk("mult_mdctr_nop", {29'h0, MD_ctr}, 32'h7);
      next_cycle();
    end
    @(negedge clk);
    chk("mult_stall_end", {31'h0, stall}, 32'h0);
    chk("mult_mflo", mf_result, 32'hFFFF_FFEB);
    next_cycle();
    ex_mf_sel = 1'b0;
    @(negedge clk);
    chk("mult_mfhi", mf_result, 32'hFFFF_FFFF);
    chk("mult_laterr", {31'h0, lat_err}, 32'h0);
    next_cycle();

    // divu 100 / 7 followed by mfhi
    issue(3'b011, 32'd100, 32'd7);
    @(negedge clk);
    chk("divu_start", {31'h0, Start}, 32'h1);
    next_cycle();
    idle_inputs(); ex_is_mf = 1'b1;
    for (int k = 1; k <= DIV_LAT + 2; k++) begin
      @(negedge clk);
      chk("divu_stall", {31'h0, stall}, 32'h1);
      next_cycle();
    end
    @(negedge clk);
    chk("divu_stall_end", {31'h0, stall}, 32'h0);
    chk("divu_mfhi", mf_result, 32'd2);
    next_cycle();
    ex_mf_sel = 1'b1;
    @(negedge clk);
    chk("divu_mflo", mf_result, 32'd14);
    next_cycle();

    // mthi while idle
    issue(3'b100, 32'h1234_5678, 32'h0);
    @(negedge clk);
    chk("mthi_start", {31'h0, Start}, 32'h0);
    chk("mthi_mdctr", {29'h0, MD_ctr}, 32'h4);
    chk("mthi_rd1", RD1, 32'h1234_5678);
    next_cycle();
    idle_inputs(); ex_is_mf = 1'b1;
    @(negedge clk);
    chk("mthi_mdctr_after", {29'h0, MD_ctr}, 32'h7);
    chk("mthi_stall", {31'h0, stall}, 32'h0);
    chk("mthi_mfhi", mf_result, 32'h1234_5678);
    next_cycle();

    // flushed mult, then madd / undefined
    issue(3'b000, 32'd5, 32'd6);
    ex_flush = 1'b1;
    @(negedge clk);
    chk("flush_start", {31'h0, Start}, 32'h0);
    chk("flush_mdctr", {29'h0, MD_ctr}, 32'h7);
    chk("flush_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    idle_inputs(); ex_is_mf = 1'b1;
    @(negedge clk);
    chk("flush_still_idle", {31'h0, stall}, 32'h0);
    next_cycle();
    issue(3'b110, 32'd1, 32'd2);
    @(negedge clk);
    chk("madd_illegal", {31'h0, illegal_op}, 32'h1);
    chk("madd_start", {31'h0, Start}, 32'h0);
    chk("madd_mdctr", {29'h0, MD_ctr}, 32'h7);
    chk("madd_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    issue(3'b111, 32'd1, 32'd2);
    @(negedge clk);
    chk("undef_illegal", {31'h0, illegal_op}, 32'h1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("illegal_pulse_end", {31'h0, illegal_op}, 32'h0);
    next_cycle();

    // Busy stuck high for 20 cycles
    busy_override = 20;
    issue(3'b000, 32'd1, 32'd1);
    @(negedge clk);
    chk("wdog_start", {31'h0, Start}, 32'h1);
    next_cycle();
    busy_override = 0;
    idle_inputs(); ex_is_mf = 1'b1;
    for (int k = 1; k <= WDOG_MAX + 1; k++) begin
      @(negedge clk);
      chk("wdog_stall", {31'h0, stall}, 32'h1);
      if (k == WDOG_MAX + 1) chk("wdog_laterr", {31'h0, lat_err}, 32'h1);
      next_cycle();
    end
    @(negedge clk);
    chk("wdog_back_idle", {31'h0, stall}, 32'h0);
    chk("wdog_busy_still_high", {31'h0, Busy}, 32'h1);
    next_cycle();
    idle_inputs();
    begin
      int w;
      w = 0;
      while (Busy && w < 20) begin
        next_cycle();
        w++;
      end
    end
    chk("wdog_busy_release", {31'h0, Busy}, 32'h0);
    chk("wdog_laterr_sticky", {31'h0, lat_err}, 32'h1);

    // asynchronous reset during WAIT of a div
    issue(3'b011, 32'd50, 32'd5);
    @(negedge clk);
    chk("arst_start", {31'h0, Start}, 32'h1);
    next_cycle();
    idle_inputs(); ex_is_mf = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("arst_pre_stall", {31'h0, stall}, 32'h1);
      next_cycle();
    end
    ex_valid = 1'b1; ex_md_ctr = 3'b000; ex_rs = 32'hDEAD_BEEF; ex_rt = 32'h2;
    #1 chk("arst_stall_before", {31'h0, stall}, 32'h1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("arst");
    @(posedge clk);
    #2 reset = 1'b1;
    idle_inputs();
    next_cycle();

    // Busy drops one cycle early
    busy_override = MUL_LAT - 1;
    issue(3'b001, 32'd3, 32'd3);
    @(negedge clk);
    chk("early_start", {31'h0, Start}, 32'h1);
    chk("early_laterr_before", {31'h0, lat_err}, 32'h0);
    next_cycle();
    busy_override = 0;
    idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) chk("early_laterr_mid", {31'h0, lat_err}, 32'h0);
      if (k == 6) chk("early_laterr", {31'h0, lat_err}, 32'h1);
      next_cycle();
    end
    do_reset();

    // randomized phase against a cycle-count model
    cyc = 0;
    free_at = 0;
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind      = int'($urandom_range(0, 3));
      ex_valid  = (kind < 2);
      ex_is_mf  = (kind == 2);
      ex_md_ctr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      ex_flush  = ($urandom_range(0, 7) == 0);
      ex_mf_sel = 1'($urandom_range(0, 1));
      ex_rs     = $urandom;
      ex_rt     = $urandom;
      if (ex_rt == 32'h0) ex_rt = 32'h1;

      m_idle  = (cyc >= free_at);
      m_live  = ex_valid && !ex_flush;
      e_start = m_live && m_idle && (ex_md_ctr < 3'd4);
      e_md    = (m_live && m_idle && ex_md_ctr < 3'd6) ? ex_md_ctr : 3'd7;
      e_ill   = m_live && m_idle && (ex_md_ctr >= 3'd6);
      e_stall = (ex_valid || ex_is_mf) && !ex_flush && !m_idle;

      @(negedge clk);
      chk("rnd_start", {31'h0, Start}, {31'h0, e_start});
      chk("rnd_mdctr", {29'h0, MD_ctr}, {29'h0, e_md});
      chk("rnd_illegal", {31'h0, illegal_op}, {31'h0, e_ill});
      chk("rnd_stall", {31'h0, stall}, {31'h0, e_stall});
      chk("rnd_laterr", {31'h0, lat_err}, 32'h0);
      if (e_md != 3'd7) chk("rnd_rd1", RD1, ex_rs);
      if (e_start) chk("rnd_rd2", RD2, ex_rt);
      if (ex_is_mf && !e_stall) chk("rnd_mf", mf_result, ex_mf_sel ? u_lo : u_hi);

      if (e_start) begin
        lat = ex_md_ctr[1] ? DIV_LAT : MUL_LAT;
        free_at = cyc + lat + 3;
      end
      next_cycle();
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
